// File: rtl/amiga_daug_dram.sv
// 68000-to-DRAM controller: multiplexed row/column access, CAS-before-RAS refresh.
// Define DAUG_WOM_EN to enable the write-once (WPRO_LOCK) write protection.
module amiga_daug_dram #(
  parameter int BANKS       = 2,
  parameter int ROW_BITS    = 8,
  parameter int BASE        = 0,
  parameter int TRP         = 2,
  parameter int TRAS_REF    = 3,
  parameter int REFRESH_DIV = 112
) (
  input  logic                CLK,
  input  logic                _RST,
  input  logic [23:1]         A,
  input  logic                _AS,
  input  logic                _UDS,
  input  logic                _LDS,
  input  logic                _PRW,
  input  logic                WPRO_LOCK,
  output logic                _DTACK,
  output logic [ROW_BITS-1:0] MA,
  output logic [BANKS-1:0]    _RAS,
  output logic                _UCAS,
  output logic                _LCAS,
  output logic                _WE,
  output logic                _WPRO,
  output logic                REF_OVF
);

  localparam int BB = $clog2(BANKS);
  localparam int BW = (BB > 0) ? BB : 1;
  localparam int UL = 2*ROW_BITS + BB + 1;
  localparam int UW = 24 - UL;
  localparam logic [UW-1:0] BASE_U    = UW'(BASE);
  localparam logic [11:0]   DIV_LAST  = 12'(REFRESH_DIV - 1);
  localparam logic [2:0]    TRP_LOAD  = 3'(TRP - 1);
  localparam logic [2:0]    TRAS_LOAD = 3'(TRAS_REF - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ROW     = 3'd1;
  localparam logic [2:0] S_COL     = 3'd2;
  localparam logic [2:0] S_HOLD    = 3'd3;
  localparam logic [2:0] S_PRE     = 3'd4;
  localparam logic [2:0] S_REF_CAS = 3'd5;
  localparam logic [2:0] S_REF_RAS = 3'd6;

  logic [2:0]          state, tmr;
  logic [11:0]         ref_cnt;
  logic                pending, wrap, refresh_req, access_req, hit, wp_block;
  logic [ROW_BITS-1:0] row_q, col_q;
  logic [BW-1:0]       bank_a, bank_q;
  logic [BANKS-1:0]    ras_sel;

  generate
    if (BB > 0) begin : g_bank
      assign bank_a = A[2*ROW_BITS+BB : 2*ROW_BITS+1];
    end else begin : g_one_bank
      assign bank_a = '0;
    end
  endgenerate

  assign hit         = (A[23:UL] == BASE_U);
  assign wrap        = (ref_cnt == DIV_LAST);
  // A wrap in this very cycle already counts, so refresh beats a same-cycle access.
  assign refresh_req = pending | wrap;
  assign access_req  = hit & ~_AS & (~_UDS | ~_LDS);
  assign ras_sel     = ~(BANKS'(1) << bank_q);

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      state   <= S_IDLE;
      tmr     <= '0;
      ref_cnt <= '0;
      pending <= 1'b0;
      REF_OVF <= 1'b0;
      // NOTE: the address latches are reset as well so MA never carries X out of reset.
      row_q   <= '0;
      col_q   <= '0;
      bank_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every decision below sees pre-edge values.
      ref_cnt <= wrap ? 12'd0 : ref_cnt + 12'd1;
      REF_OVF <= REF_OVF | (wrap & pending);
      pending <= refresh_req & (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (refresh_req) begin
            state <= S_REF_CAS;
          end else if (access_req) begin
            state  <= S_ROW;
            row_q  <= A[2*ROW_BITS:ROW_BITS+1];
            col_q  <= A[ROW_BITS:1];
            bank_q <= bank_a;
          end
        end
        S_ROW: begin
          if (_AS) begin
            state <= S_PRE;
            tmr   <= TRP_LOAD;
          end else begin
            state <= S_COL;
          end
        end
        S_COL:  state <= S_HOLD;
        S_HOLD: begin
          if (_AS) begin
            state <= S_PRE;
            tmr   <= TRP_LOAD;
          end
        end
        S_PRE: begin
          if (tmr == 3'd0) state <= S_IDLE;
          else             tmr   <= tmr - 3'd1;
        end
        S_REF_CAS: begin
          state <= S_REF_RAS;
          tmr   <= TRAS_LOAD;
        end
        S_REF_RAS: begin
          if (tmr == 3'd0) begin
            state <= S_PRE;
            tmr   <= TRP_LOAD;
          end else begin
            tmr <= tmr - 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DAUG_WOM_EN
  assign wp_block = ~_WPRO & ~_PRW;

  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) _WPRO <= 1'b1;
    else       _WPRO <= _WPRO & ~WPRO_LOCK;
  end
`else
  logic unused_wpro_lock;
  assign unused_wpro_lock = WPRO_LOCK;
  assign wp_block         = 1'b0;
  assign _WPRO            = 1'b1;
`endif

  // Strobes are decoded from the current state, so they trail the FSM by one clock.
  always_ff @(posedge CLK or negedge _RST) begin
    if (!_RST) begin
      MA     <= '0;
      _RAS   <= '1;
      _UCAS  <= 1'b1;
      _LCAS  <= 1'b1;
      _WE    <= 1'b1;
      _DTACK <= 1'b1;
    end else begin
      case (state)
        S_ROW: begin
          MA     <= row_q;
          _RAS   <= ras_sel;
          _UCAS  <= 1'b1;
          _LCAS  <= 1'b1;
          _WE    <= 1'b1;
          _DTACK <= 1'b1;
        end
        S_COL: begin
          MA     <= col_q;
          _RAS   <= ras_sel;
          _UCAS  <= _UDS | wp_block;
          _LCAS  <= _LDS | wp_block;
          _WE    <= _PRW | wp_block;
          _DTACK <= 1'b0;
        end
        S_HOLD: begin
        end
        S_REF_CAS, S_REF_RAS: begin
          MA     <= '0;
          _RAS   <= (state == S_REF_RAS) ? '0 : '1;
          _UCAS  <= 1'b0;
          _LCAS  <= 1'b0;
          _WE    <= 1'b1;
          _DTACK <= 1'b1;
        end
        default: begin
          MA     <= '0;
          _RAS   <= '1;
          _UCAS  <= 1'b1;
          _LCAS  <= 1'b1;
          _WE    <= 1'b1;
          _DTACK <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amiga_daug_dram.sv
// Bench for amiga_daug_dram: timeline-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized bus traffic.
module tb_amiga_daug_dram;

  localparam int ROW_BITS = 8;
  localparam int BANKS    = 2;
  localparam int BASE     = 0;
  localparam int TRP      = 2;
  localparam int TRAS     = 3;
  localparam int DIV      = 112;

  typedef struct packed {
    logic                dtack_n;
    logic [ROW_BITS-1:0] ma;
    logic [BANKS-1:0]    ras_n;
    logic                ucas_n;
    logic                lcas_n;
    logic                we_n;
    logic                wpro_n;
    logic                ref_ovf;
  } outs_t;

  typedef enum {K_NONE, K_ACC, K_REF} txn_e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [23:1] a = '0;
  logic as_n = 1'b1, uds_n = 1'b1, lds_n = 1'b1, prw_n = 1'b1, wpro_lock = 1'b0;
  logic dtack_n, ucas_n, lcas_n, we_n, wpro_n, ref_ovf;
  logic [ROW_BITS-1:0] ma;
  logic [BANKS-1:0] ras_n;
  outs_t dut_o;

  int checks = 0;
  int errors = 0;

  amiga_daug_dram #(
    .BANKS(BANKS), .ROW_BITS(ROW_BITS), .BASE(BASE),
    .TRP(TRP), .TRAS_REF(TRAS), .REFRESH_DIV(DIV)
  ) dut (
    .CLK(clk), ._RST(rst_n), .A(a), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n),
    ._PRW(prw_n), .WPRO_LOCK(wpro_lock), ._DTACK(dtack_n), .MA(ma), ._RAS(ras_n),
    ._UCAS(ucas_n), ._LCAS(lcas_n), ._WE(we_n), ._WPRO(wpro_n), .REF_OVF(ref_ovf)
  );

  assign dut_o = {dtack_n, ma, ras_n, ucas_n, lcas_n, we_n, wpro_n, ref_ovf};

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic outs_t quiet_o();
    outs_t o;
    o.dtack_n = 1'b1; o.ma = '0; o.ras_n = '1; o.ucas_n = 1'b1;
    o.lcas_n = 1'b1;  o.we_n = 1'b1; o.wpro_n = 1'b1; o.ref_ovf = 1'b0;
    return o;
  endfunction

  // ---------------- reference model: transactions on an edge timeline ----------------
  outs_t exp_o;
  txn_e  kind;
  int    edge_cnt, t0, rel_at, free_at;
  bit    pend, ovf, lock;
  logic [ROW_BITS-1:0] m_row, m_col;
  int    m_bank;

  always @(posedge clk or negedge rst_n) begin
    outs_t o;
    bit wrap, entry, wp;
    int k;
    if (!rst_n) begin
      exp_o = quiet_o(); kind = K_NONE; edge_cnt = -1;
      pend = 0; ovf = 0; lock = 0; t0 = 0; rel_at = -1; free_at = 0;
    end else begin
      edge_cnt++;
      wrap  = (edge_cnt % DIV) == DIV - 1;
      k     = edge_cnt - t0;
      wp    = 1'b0;
`ifdef DAUG_WOM_EN
      wp    = lock && !prw_n;
`endif
      o = quiet_o();
      if (kind == K_ACC && !(rel_at >= 0 && edge_cnt > rel_at)) begin
        if (k == 1) begin
          o.ma = m_row; o.ras_n[m_bank] = 1'b0;
        end else if (k == 2) begin
          o.ma = m_col; o.ras_n[m_bank] = 1'b0; o.dtack_n = 1'b0;
          o.ucas_n = uds_n | wp; o.lcas_n = lds_n | wp; o.we_n = prw_n | wp;
        end else if (k >= 3) begin
          o = exp_o;
        end
      end else if (kind == K_REF) begin
        if (k >= 1 && k <= 1 + TRAS) begin
          o.ucas_n = 1'b0; o.lcas_n = 1'b0;
          if (k >= 2) o.ras_n = '0;
        end
      end
      if (kind == K_ACC && rel_at < 0 && (k == 1 || k >= 3) && as_n) begin
        rel_at = edge_cnt; free_at = edge_cnt + 1 + TRP;
      end
      if (kind != K_NONE && edge_cnt == free_at) kind = K_NONE;
      entry = 0;
      if (kind == K_NONE) begin
        if (pend || wrap) begin
          kind = K_REF; t0 = edge_cnt; free_at = edge_cnt + 2 + TRAS + TRP; entry = 1;
        end else if (a[23:18] == 6'(BASE) && !as_n && (!uds_n || !lds_n)) begin
          kind = K_ACC; t0 = edge_cnt; rel_at = -1; free_at = 1 << 30;
          m_row = a[16:9]; m_col = a[8:1]; m_bank = int'(a[17]);
        end
      end
      ovf  = ovf || (wrap && pend);
      pend = (pend || wrap) && !entry;
`ifdef DAUG_WOM_EN
      lock = lock || wpro_lock;
`endif
      o.wpro_n  = !lock;
      o.ref_ovf = ovf;
      exp_o = o;
    end
  end

  always @(negedge clk) if (rst_n) check("outputs", dut_o, exp_o);

  // ---------------- stimulus helpers ----------------
  task automatic at_edge(input int n);
    int guard = 0;
    while (edge_cnt < n && guard < 5000) begin
      @(posedge clk); #1; guard++;
    end
    if (edge_cnt < n) check("edge_timeout", 64'(edge_cnt), 64'(n));
  endtask

  task automatic drive(input logic [23:0] addr, input logic as, input logic uds,
                       input logic lds, input logic prw);
    a = addr[23:1]; as_n = as; uds_n = uds; lds_n = lds; prw_n = prw;
  endtask

  task automatic wait_dtack(output bit ok);
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk); #1;
      if (!dtack_n) ok = 1;
    end
  endtask

  initial begin
    bit ok;
    int ras_low;
    logic [23:0] ad;

    // Reset values
    #23;
    check("rst_ras", ras_n, 2'b11);
    check("rst_ma", ma, 8'h00);
    check("rst_strobes", {ucas_n, lcas_n, we_n, dtack_n, wpro_n, ref_ovf}, 6'b111110);
    @(negedge clk); rst_n = 1'b1;

    // Read at 0x00A466, both strobes
    at_edge(4);  drive(24'h00A466, 0, 0, 0, 1);
    at_edge(5);  check("rd_idle_dtack", dtack_n, 1'b1);
    at_edge(6);  check("rd_row_ras", ras_n, 2'b10); check("rd_row_ma", ma, 8'h52);
    at_edge(7);  check("rd_col_ma", ma, 8'h33);
    check("rd_col", {ucas_n, lcas_n, we_n, dtack_n}, 4'b0010);
    as_n = 1; uds_n = 1; lds_n = 1;
    at_edge(8);  check("rd_hold_dtack", dtack_n, 1'b0);
    at_edge(9);  check("rd_pre_dtack", dtack_n, 1'b1);

    // Byte write at 0x020000, lower strobe only; PRE must last TRP clocks
    at_edge(11); drive(24'h020000, 0, 1, 0, 0);
    at_edge(13); check("wr_row_ras", ras_n, 2'b01); check("wr_row_ma", ma, 8'h00);
    at_edge(14); check("wr_col", {ucas_n, lcas_n, we_n, dtack_n}, 4'b1000);
    as_n = 1; lds_n = 1;
    at_edge(15); drive(24'h00A466, 0, 0, 0, 1);
    for (int e = 16; e <= 18; e++) begin
      at_edge(e); check("wr_pre_ras", ras_n, 2'b11);
    end
    at_edge(19); check("pre_end_ras", ras_n, 2'b10);
    at_edge(20); as_n = 1; uds_n = 1; lds_n = 1;

    // Access in the wrap cycle: refresh first, then the access
    at_edge(110); drive(24'h00A466, 0, 0, 0, 1);
    at_edge(112); check("ref_cas", {ras_n, ucas_n, lcas_n}, 4'b1100);
    ras_low = 0;
    for (int e = 113; e <= 118; e++) begin
      at_edge(e);
      if (ras_n == 2'b00) ras_low++;
    end
    check("ref_ras_clocks", 64'(ras_low), 64'd3);
    at_edge(119); check("ref_then_row", ras_n, 2'b10);
    at_edge(120); check("ref_then_dtack", dtack_n, 1'b0);

    // _AS held low through two wraps -> sticky overrun
    at_edge(334); check("ovf_before", ref_ovf, 1'b0);
    at_edge(335); check("ovf_set", ref_ovf, 1'b1);
    at_edge(340); as_n = 1; uds_n = 1; lds_n = 1;
    at_edge(400); check("ovf_sticky", ref_ovf, 1'b1);

    // Reset asynchronously in HOLD
    drive(24'h00A466, 0, 0, 0, 1);
    wait_dtack(ok); check("hold_dtack_seen", ok, 1'b1);
    @(posedge clk); #3; rst_n = 1'b0; #1;
    check("arst_ras", ras_n, 2'b11);
    check("arst_strobes", {ucas_n, lcas_n, we_n, dtack_n}, 4'b1111);
    check("arst_ma_ovf", {ma, ref_ovf}, 9'h000);

    // Strobes already low at release are serviced
    @(negedge clk); rst_n = 1'b1;
    at_edge(1); check("rel_row_ras", ras_n, 2'b10);
    at_edge(2); check("rel_dtack", dtack_n, 1'b0);
    as_n = 1; uds_n = 1; lds_n = 1;

    // Miss: upper bits differ from BASE
    at_edge(6); drive(24'hFC0000, 0, 0, 0, 1);
    for (int e = 7; e <= 14; e++) begin
      at_edge(e); check("miss_quiet", {ras_n, ucas_n, lcas_n, dtack_n}, 5'b11111);
    end
    as_n = 1; uds_n = 1; lds_n = 1;

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (as_n) begin
        ad = {($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'(BASE), 18'($urandom)};
        a = ad[23:1];
        prw_n = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 3) == 0) as_n = ~as_n;
      if ($urandom_range(0, 3) == 0) {uds_n, lds_n} = 2'($urandom_range(0, 3));
      wpro_lock = ($urandom_range(0, 499) == 0);
    end
    wpro_lock = 0; as_n = 1; uds_n = 1; lds_n = 1;
    repeat (30) @(posedge clk);
    #1;

    // Write protection
    wpro_lock = 1; @(posedge clk); #1; wpro_lock = 0;
    @(posedge clk); #1;
`ifdef DAUG_WOM_EN
    check("wom_wpro", wpro_n, 1'b0);
    drive(24'h00A466, 0, 0, 0, 0);
    wait_dtack(ok); check("wom_wr_dtack", ok, 1'b1);
    check("wom_wr_blocked", {ucas_n, lcas_n, we_n}, 3'b111);
    as_n = 1; uds_n = 1; lds_n = 1;
    repeat (6) @(posedge clk);
    #1; drive(24'h00A466, 0, 0, 0, 1);
    wait_dtack(ok); check("wom_rd_dtack", ok, 1'b1);
    check("wom_rd_cas", {ucas_n, lcas_n, we_n}, 3'b001);
`else
    check("wom_off_wpro", wpro_n, 1'b1);
    drive(24'h00A466, 0, 0, 0, 0);
    wait_dtack(ok); check("wom_off_dtack", ok, 1'b1);
    check("wom_off_write", {ucas_n, lcas_n, we_n}, 3'b000);
`endif
    as_n = 1; uds_n = 1; lds_n = 1;
    repeat (10) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/amiga_daug_dram.md
AMIGA_DAUG_DRAM -- requirements
Module: amiga_daug_dram

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- BANKS, 2, RAS banks (1, 2 or 4).
- ROW_BITS, 8, multiplexed DRAM address width (8..10).
- BASE, 0, value matched against A[23:2*ROW_BITS+log2(BANKS)+1].
- TRP, 2, precharge clocks (1..7).
- TRAS_REF, 3, refresh RAS-low clocks (1..7).
- REFRESH_DIV, 112, clocks between refresh requests (2..4095).

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- CLK, in, 1, sole clock, rising edge.
- _RST, in, 1, asynchronous active-low reset.
- A, in, [23:1], 68000 word address.
- _AS, in, 1, address strobe (active low).
- _UDS, in, 1, upper data strobe (active low).
- _LDS, in, 1, lower data strobe (active low).
- _PRW, in, 1, 1 = read, 0 = write.
- WPRO_LOCK, in, 1, write-protect lock strobe.
- _DTACK, out, 1, transfer acknowledge.
- MA, out, ROW_BITS, DRAM row/column address.
- _RAS, out, BANKS, per-bank row strobes.
- _UCAS, out, 1, upper byte column strobe.
- _LCAS, out, 1, lower byte column strobe.
- _WE, out, 1, DRAM write enable.
- _WPRO, out, 1, low while write-protected.
- REF_OVF, out, 1, sticky refresh-overrun flag.

Function
REQ-003 Address split SHALL be: column = A[ROW_BITS:1]; row = A[2*ROW_BITS:ROW_BITS+1]; bank = the next log2(BANKS) bits. The remaining upper bits SHALL equal BASE for a hit.
REQ-004 FSM states SHALL be IDLE, ROW, COL, HOLD, PRE, REF_CAS, REF_RAS. All outputs SHALL be registered.
REQ-005 IDLE: when a refresh is pending, the FSM SHALL go to REF_CAS, even if an access is requested in the same cycle.
REQ-006 IDLE: otherwise, on hit && !_AS && (!_UDS || !_LDS), the FSM SHALL go to ROW. In ROW, MA = row and the selected _RAS bit is low.
REQ-007 ROW -> COL after 1 clock. In COL: MA = column; _UCAS = _UDS; _LCAS = _LDS; _WE = _PRW; _DTACK low. Latency from strobe sample to _DTACK low SHALL be 2 clocks.
REQ-008 COL -> HOLD after 1 clock. HOLD SHALL keep RAS, CAS, _WE and _DTACK until _AS is sampled high, then go to PRE.
REQ-009 If _AS goes high while in ROW, the FSM SHALL go directly to PRE without asserting CAS or _DTACK.
REQ-010 PRE SHALL negate all strobes and _DTACK, hold for TRP clocks, then return to IDLE.
REQ-011 Refresh is CAS-before-RAS:
- REF_CAS: both CAS low for 1 clock.
- REF_RAS: all _RAS low with CAS held low for TRAS_REF clocks.
- Then PRE.
REQ-012 The refresh counter SHALL run 0..REFRESH_DIV-1 and wrap to 0. On each wrap it SHALL set pending. Pending SHALL clear on entry to REF_CAS.
REQ-013 A wrap while pending is already set SHALL set REF_OVF. REF_OVF SHALL clear only by reset.
REQ-014 A miss (upper address bits not equal to BASE) SHALL leave every output inactive.

Reset
REQ-015 _RST low SHALL asynchronously force the following, regardless of state:
- FSM to IDLE; counter, pending, REF_OVF and lock to 0.
- _RAS all 1; _UCAS, _LCAS, _WE, _DTACK, _WPRO to 1; MA to 0.
REQ-016 Release of _RST SHALL take effect on the next rising CLK. Access strobes already low at release SHALL be serviced normally.

Configuration
REQ-017 Macro DAUG_WOM_EN SHALL control write protection.
- Defined: WPRO_LOCK sampled high in any state SHALL set a lock bit; _WPRO = !lock.
- While locked, write cycles SHALL run the normal FSM with _DTACK asserted, but CAS and _WE held high. Reads are unaffected.
- Undefined: WPRO_LOCK is ignored, _WPRO stays 1 and writes are always performed.

Verification
REQ-018 The bench SHALL cover these scenarios:
- Defaults; read at 0x00A466 (_UDS=0, _LDS=0) -> _RAS[0] low with MA=0x52 in ROW; then MA=0x33, both CAS low, _WE=1, _DTACK low 2 clocks after strobes.
- Byte write at 0x020000, _LDS only -> _RAS[1] low, _LCAS low, _UCAS high, _WE low; after _AS high, PRE lasts 2 clocks.
- Access request in the same cycle the refresh counter wraps -> REF_CAS first, all _RAS low for 3 clocks, then the access completes.
- _AS held low across 2*REFRESH_DIV clocks -> REF_OVF=1, which persists until _RST.
- _RST low mid-HOLD -> all strobes and _DTACK high immediately, without waiting for CLK.
- DAUG_WOM_EN defined: WPRO_LOCK pulse, then write -> _WPRO=0, _DTACK low, CAS and _WE stay high; a read still asserts CAS.
